// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and line levels.
package uart_pkg;

    // Receiver states; WAIT_IDLE extends the transmitter's 3-bit state space.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam logic        UART_IDLE_LEVEL  = 1'b1;
    localparam logic        UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both reset to the line's inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver: synchronises the serial line, validates the start bit
// mid-bit, shifts in 8 data bits LSB first and checks the stop bit.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Done,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_sync2 #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (i_Rx_Serial),
        .q_o   (rx_s)
    );

    uart_state_e                state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]  byte_q, byte_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       active_q, active_d;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            done_q   <= done_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    // Next-state and output decode; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_s == UART_START_LEVEL) begin
                    // With HALF=0 the detection sample is already mid-bit.
                    if (HALF == 0) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = (rx_s == UART_START_LEVEL) ? DATA : IDLE;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        byte_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end

    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Done      = done_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench: three receivers (CLKS_PER_BIT 1, 7, 16) driven in parallel.
module tb_uart_rx_controller;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         edge_no;
    } exp_t;

    logic       clk;
    logic       ser    [3];
    logic       rstn   [3];
    logic [7:0] rbyte  [3];
    logic       done   [3];
    logic       active [3];
    logic       ferr   [3];

    int         cpb_of [3];
    exp_t       expq   [3][$];
    logic [7:0] last_good [3];
    logic [7:0] held   [3];
    bit         no_active [3];
    int         cyc;
    int         checks;
    int         fails;

    uart_rx_controller #(.CLKS_PER_BIT(1)) u_c1 (
        .clk(clk), .reset_n(rstn[0]), .i_Rx_Serial(ser[0]), .o_Rx_Byte(rbyte[0]),
        .o_Rx_Done(done[0]), .o_Rx_Active(active[0]), .o_Rx_Frame_Err(ferr[0]));
    uart_rx_controller #(.CLKS_PER_BIT(7)) u_c7 (
        .clk(clk), .reset_n(rstn[1]), .i_Rx_Serial(ser[1]), .o_Rx_Byte(rbyte[1]),
        .o_Rx_Done(done[1]), .o_Rx_Active(active[1]), .o_Rx_Frame_Err(ferr[1]));
    uart_rx_controller #(.CLKS_PER_BIT(16)) u_c16 (
        .clk(clk), .reset_n(rstn[2]), .i_Rx_Serial(ser[2]), .o_Rx_Byte(rbyte[2]),
        .o_Rx_Done(done[2]), .o_Rx_Active(active[2]), .o_Rx_Frame_Err(ferr[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s (inst %0d) at edge %0d: actual=%0h required=%0h",
                     name, inst, cyc, act, req);
        end
    endtask

    // Drives nbits of a frame (start, 8 data LSB first, stop). Only a full frame
    // is entered in the scoreboard. Jitter shifts each inner bit boundary by -1..+1.
    task automatic send_frame(input int i, input logic [7:0] b, input bit stop,
                              input bit jit, input int nbits);
        int off [11];
        logic [9:0] bits;
        int cpb;
        exp_t e;
        cpb = cpb_of[i];
        bits = {stop, b, 1'b0};
        off[0] = 0;
        off[10] = 0;
        for (int k = 1; k < 10; k++) off[k] = jit ? (int'($urandom_range(2)) - 1) : 0;
        if (nbits == 10) begin
            e.err = !stop;
            e.data = stop ? b : last_good[i];
            e.edge_no = cyc + 1 + 2 + (cpb - 1) / 2 + 9 * cpb;
            expq[i].push_back(e);
            if (stop) last_good[i] = b;
        end
        for (int k = 0; k < nbits; k++) begin
            ser[i] = bits[k];
            repeat (cpb + off[k+1] - off[k]) @(negedge clk);
        end
    endtask

    task automatic idle(input int i, input int n);
        ser[i] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a receiver pulses Done or Frame_Err.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                held[i] = 8'h00;
            end else begin
                if (done[i] || ferr[i]) begin
                    check(!(done[i] && ferr[i]), "done_err_overlap", i, 32'(ferr[i]), 0);
                    if (expq[i].size() == 0) begin
                        check(1'b0, "unexpected_output", i, 32'(rbyte[i]), 0);
                    end else begin
                        exp_t e;
                        e = expq[i].pop_front();
                        check(ferr[i] == e.err, "err_flag", i, 32'(ferr[i]), 32'(e.err));
                        check(rbyte[i] == e.data, "rx_byte", i, 32'(rbyte[i]), 32'(e.data));
                        check(cyc == e.edge_no, "latency_edge", i, 32'(cyc), 32'(e.edge_no));
                        if (!e.err) held[i] = e.data;
                    end
                end else begin
                    check(rbyte[i] == held[i], "byte_stable", i, 32'(rbyte[i]), 32'(held[i]));
                end
                if (no_active[i]) check(!active[i], "no_active", i, 32'(active[i]), 0);
            end
        end
    end

    initial begin
        checks = 0;
        fails = 0;
        cpb_of[0] = 1;
        cpb_of[1] = 7;
        cpb_of[2] = 16;
        for (int i = 0; i < 3; i++) begin
            ser[i] = 1'b1;
            rstn[i] = 1'b0;
            last_good[i] = 8'h00;
            held[i] = 8'h00;
            no_active[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check(rbyte[i] == 8'h00, "reset_byte", i, 32'(rbyte[i]), 0);
            check(!done[i], "reset_done", i, 32'(done[i]), 0);
            check(!ferr[i], "reset_err", i, 32'(ferr[i]), 0);
            check(!active[i], "reset_active", i, 32'(active[i]), 0);
        end
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        repeat (4) @(negedge clk);

        fork
            begin : c1_stream
                send_frame(0, 8'hA5, 1'b1, 1'b0, 10);
                idle(0, 5);
                for (int n = 0; n < 1000; n++) begin
                    send_frame(0, 8'($urandom), 1'b1, 1'b0, 10);
                    idle(0, int'($urandom_range(3)));
                end
            end
            begin : c7_jitter
                for (int n = 0; n < 300; n++) begin
                    send_frame(1, 8'($urandom), 1'b1, 1'b1, 10);
                    idle(1, int'($urandom_range(4)));
                end
            end
            begin : c16_directed
                send_frame(2, 8'h00, 1'b1, 1'b0, 10);
                send_frame(2, 8'hFF, 1'b1, 1'b0, 10);
                send_frame(2, 8'h5A, 1'b1, 1'b0, 10);
                idle(2, 20);
                check(!active[2], "idle_after_burst", 2, 32'(active[2]), 0);

                ser[2] = 1'b0;
                repeat (3) @(negedge clk);
                idle(2, 30);
                check(!active[2], "glitch_rejected", 2, 32'(active[2]), 0);
                send_frame(2, 8'h3C, 1'b1, 1'b0, 10);
                idle(2, 20);

                send_frame(2, 8'h81, 1'b0, 1'b0, 10);
                no_active[2] = 1'b1;
                ser[2] = 1'b0;
                repeat (40) @(negedge clk);
                ser[2] = 1'b1;
                repeat (2) @(negedge clk);
                no_active[2] = 1'b0;
                idle(2, 20);
                send_frame(2, 8'h42, 1'b1, 1'b0, 10);
                idle(2, 20);

                send_frame(2, 8'hE7, 1'b1, 1'b0, 5);
                ser[2] = 1'b0;
                repeat (8) @(negedge clk);
                check(active[2], "active_mid_frame", 2, 32'(active[2]), 1);
                rstn[2] = 1'b0;
                #1;
                check(rbyte[2] == 8'h00, "rst_mid_byte", 2, 32'(rbyte[2]), 0);
                check(!active[2], "rst_mid_active", 2, 32'(active[2]), 0);
                check(!done[2] && !ferr[2], "rst_mid_pulse", 2, 32'({done[2], ferr[2]}), 0);
                last_good[2] = 8'h00;
                @(negedge clk);
                ser[2] = 1'b1;
                repeat (3) @(negedge clk);
                rstn[2] = 1'b1;
                idle(2, 20);
                send_frame(2, 8'hC3, 1'b1, 1'b0, 10);
                idle(2, 20);
            end
        join

        for (int t = 0; t < 2000; t++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++)
            check(expq[i].size() == 0, "scoreboard_drained", i, 32'(expq[i].size()), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
